// File: rtl/mini_alu_core.sv
// mini_alu_core: two-stage (decode, execute) microcontroller core with a
// register file, return-address stack, and a ready/valid video RAM write port.
//
// Build option: define MINI_ALU_SMUL_EN to implement the SMUL multiplier;
// without it SMUL executes as a NOP and no multiplier is built.
//
// Ports:
//   Clock          system clock, all state on the rising edge
//   Reset          asynchronous active-high reset
//   oIP            instruction ROM address (combinational on taken branches)
//   iInstruction   ROM data for oIP: [27:24] op, [23:16] dst, [15:8] src1, [7:0] src0
//   oVramWrValid   video write request
//   iVramWrReady   video write accept
//   oVramWrAddr    {row, col} of the video write
//   oVramWrRGB     colour of the video write
//   oHalted        core is in HALT
//   oStackFault    sticky stack overflow/underflow flag
module mini_alu_core #(
   parameter int DATA_WIDTH     = 16,
   parameter int IP_WIDTH       = 16,
   parameter int REG_ADDR_WIDTH = 4,
   parameter int STACK_DEPTH    = 4,
   parameter int ROW_BITS       = 6,
   parameter int COL_BITS       = 7
) (
   input  logic                         Clock,
   input  logic                         Reset,
   output logic [IP_WIDTH-1:0]          oIP,
   input  logic [27:0]                  iInstruction,
   output logic                         oVramWrValid,
   input  logic                         iVramWrReady,
   output logic [ROW_BITS+COL_BITS-1:0] oVramWrAddr,
   output logic [2:0]                   oVramWrRGB,
   output logic                         oHalted,
   output logic                         oStackFault
);

   localparam int SP_W = $clog2(STACK_DEPTH + 1);

   typedef enum logic [3:0] {
      OP_NOP  = 4'd0,  OP_ADD = 4'd1,  OP_SUB = 4'd2,  OP_STO  = 4'd3,
      OP_BLE  = 4'd4,  OP_BEQ = 4'd5,  OP_JMP = 4'd6,  OP_SMUL = 4'd7,
      OP_CALL = 4'd8,  OP_RET = 4'd9,  OP_INC = 4'd10, OP_MOV  = 4'd11,
      OP_RGB  = 4'd12, OP_STC = 4'd13, OP_HLT = 4'd14
   } opcode_e;

   typedef enum logic [1:0] {S_RUN, S_STALL, S_HALT} state_e;

   state_e                  state;
   logic [27:0]             instr;
   logic [IP_WIDTH-1:0]     ip_q;
   logic [SP_W-1:0]         sp;
   logic [2:0]              colour;
   logic                    fault_q;
   logic [DATA_WIDTH-1:0]   regs  [2**REG_ADDR_WIDTH];
   // Sized to the pointer range so any pointer value is a legal index.
   logic [IP_WIDTH-1:0]     stack [2**SP_W];

   opcode_e                 op;
   logic [7:0]              dst, src1, src0;
   logic [DATA_WIDTH-1:0]   opa, opb, alu_res;
   logic                    alu_we, taken, fault, stack_full, stack_empty;
   logic [IP_WIDTH-1:0]     target, fetch_ip;
   logic [SP_W-1:0]         sp_top;

   assign op   = opcode_e'(instr[27:24]);
   assign dst  = instr[23:16];
   assign src1 = instr[15:8];
   assign src0 = instr[7:0];

   // Operands are read in the execute stage, after the previous instruction's
   // write has landed, so back-to-back dependencies see the new value.
   assign opa = regs[src1[REG_ADDR_WIDTH-1:0]];
   assign opb = regs[src0[REG_ADDR_WIDTH-1:0]];

   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign sp_top      = sp - 1'b1;

   always_comb begin
      alu_we  = 1'b0;
      alu_res = '0;
      taken   = 1'b0;
      fault   = 1'b0;
      target  = IP_WIDTH'(dst);
      if (state == S_RUN) begin
         case (op)
            OP_ADD:  begin alu_we = 1'b1; alu_res = opa + opb; end
            OP_SUB:  begin alu_we = 1'b1; alu_res = opa - opb; end
`ifdef MINI_ALU_SMUL_EN
            // Low half of the full product equals the truncated product.
            OP_SMUL: begin alu_we = 1'b1; alu_res = opa * opb; end
`endif
            OP_INC:  begin alu_we = 1'b1; alu_res = opa + 1'b1; end
            OP_MOV:  begin alu_we = 1'b1; alu_res = opa; end
            OP_STO:  begin alu_we = 1'b1; alu_res = DATA_WIDTH'({src1, src0}); end
            OP_BLE:  taken = (opa <= opb);
            OP_BEQ:  taken = (opa == opb);
            OP_JMP:  taken = 1'b1;
            OP_CALL: if (stack_full) fault = 1'b1; else taken = 1'b1;
            OP_RET:  begin
               if (stack_empty) fault = 1'b1;
               else begin
                  taken  = 1'b1;
                  target = stack[sp_top];
               end
            end
            default: ;
         endcase
      end
      fetch_ip = taken ? target : ip_q;
   end

   assign oIP          = fetch_ip;
   assign oVramWrValid = (state != S_HALT) && (op == OP_STC);
   assign oVramWrAddr  = {opb[ROW_BITS-1:0], opa[COL_BITS-1:0]};
   assign oVramWrRGB   = colour;
   assign oHalted      = (state == S_HALT);
   assign oStackFault  = fault_q;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state   <= S_RUN;
         instr   <= {OP_NOP, 24'd0};
         ip_q    <= '0;
         sp      <= '0;
         colour  <= '0;
         fault_q <= 1'b0;
         for (int unsigned i = 0; i < 2**REG_ADDR_WIDTH; i++) regs[i] <= '0;
      end else begin
         case (state)
            S_RUN: begin
               if (alu_we) regs[dst[REG_ADDR_WIDTH-1:0]] <= alu_res;
               if (op == OP_RGB) colour <= src1[2:0];
               if (op == OP_CALL && !stack_full) sp <= sp + 1'b1;
               if (op == OP_RET && !stack_empty) sp <= sp_top;
               // Entering HALT or STALL freezes the fetch address and decode.
               if (fault) begin
                  fault_q <= 1'b1;
                  state   <= S_HALT;
               end else if (op == OP_HLT) begin
                  state <= S_HALT;
               end else if (op == OP_STC && !iVramWrReady) begin
                  state <= S_STALL;
               end else begin
                  instr <= iInstruction;
                  ip_q  <= fetch_ip + 1'b1;
               end
            end
            S_STALL: begin
               if (iVramWrReady) begin
                  state <= S_RUN;
                  instr <= iInstruction;
                  ip_q  <= ip_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Return addresses need no reset: the pointer alone defines valid entries.
   always_ff @(posedge Clock) begin
      if (state == S_RUN && op == OP_CALL && !stack_full) stack[sp] <= ip_q;
   end

endmodule

// File: tb/tb_mini_alu_core.sv
module tb_mini_alu_core;

   localparam int IPW  = 8;
   localparam int MASK = 'hFFFF;

   logic             Clock, Reset;
   logic [IPW-1:0]   oIP;
   logic [27:0]      iInstruction;
   logic             oVramWrValid, iVramWrReady;
   logic [12:0]      oVramWrAddr;
   logic [2:0]       oVramWrRGB;
   logic             oHalted, oStackFault;

   logic [27:0]      rom [256];
   assign iInstruction = rom[oIP];

   mini_alu_core #(
      .DATA_WIDTH(16), .IP_WIDTH(IPW), .REG_ADDR_WIDTH(4),
      .STACK_DEPTH(4), .ROW_BITS(6), .COL_BITS(7)
   ) dut (
      .Clock(Clock), .Reset(Reset), .oIP(oIP), .iInstruction(iInstruction),
      .oVramWrValid(oVramWrValid), .iVramWrReady(iVramWrReady),
      .oVramWrAddr(oVramWrAddr), .oVramWrRGB(oVramWrRGB),
      .oHalted(oHalted), .oStackFault(oStackFault)
   );

   initial begin
      Clock = 0;
      forever #5 Clock = ~Clock;
   end

   int checks = 0;
   int errors = 0;

   // ---------------- video sink: ready generator + write monitor ----------
   int          fixed_delay = 0;
   bit          rand_mode = 0;
   int          cur_delay = 0, wait_cnt = 0;
   int          stall_cycles = 0, valid_cycles = 0;
   int unsigned obs_wr[$];
   bit          hold_prev = 0;
   logic [12:0] prev_addr;
   logic [2:0]  prev_rgb;
   logic [IPW-1:0] prev_ip;

   initial begin
      iVramWrReady = 0;
      forever begin
         @(negedge Clock);
         if (Reset) begin
            wait_cnt = 0; hold_prev = 0; iVramWrReady = 0;
            cur_delay = rand_mode ? int'($urandom_range(0, 3)) : fixed_delay;
         end else if (oVramWrValid) begin
            valid_cycles++;
            if (hold_prev) begin
               checks++;
               if (oVramWrAddr !== prev_addr || oVramWrRGB !== prev_rgb || oIP !== prev_ip) begin
                  errors++;
                  $display("FAIL stall_hold: addr=%h rgb=%b ip=%h, required addr=%h rgb=%b ip=%h",
                           oVramWrAddr, oVramWrRGB, oIP, prev_addr, prev_rgb, prev_ip);
               end
            end
            if (wait_cnt < cur_delay) begin
               iVramWrReady = 0; wait_cnt++; stall_cycles++; hold_prev = 1;
               prev_addr = oVramWrAddr; prev_rgb = oVramWrRGB; prev_ip = oIP;
            end else begin
               iVramWrReady = 1;
               obs_wr.push_back({19'd0, oVramWrAddr, oVramWrRGB});
               wait_cnt = 0; hold_prev = 0;
               cur_delay = rand_mode ? int'($urandom_range(0, 3)) : fixed_delay;
            end
         end else begin
            iVramWrReady = 0; hold_prev = 0;
         end
      end
   end

   // ---------------- program helpers ---------------------------------------
   function automatic logic [27:0] mk(input int op, input int d, input int s1, input int s0);
      return {op[3:0], d[7:0], s1[7:0], s0[7:0]};
   endfunction

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = mk(14, 0, 0, 0);
   endtask

   task automatic run_prog(output int edges, output bit timed_out);
      @(negedge Clock); Reset = 1;
      @(negedge Clock); @(negedge Clock); Reset = 0;
      obs_wr.delete(); stall_cycles = 0; valid_cycles = 0;
      edges = 0; timed_out = 1;
      while (edges < 20000) begin
         @(posedge Clock); edges++;
         @(negedge Clock); #1;
         if (oHalted) begin timed_out = 0; break; end
      end
   endtask

   // ---------------- ISA-level reference model ------------------------------
   int unsigned m_regs[16];
   int unsigned m_stack[$];
   int unsigned exp_wr[$];
   bit          m_halt, m_fault;
   int          m_exec, m_halt_ip;

   task automatic model_run();
      int pc = 0, next, op, d, s1, s0;
      int unsigned a, b, colour = 0;
      logic [27:0] ins;
      foreach (m_regs[i]) m_regs[i] = 0;
      m_stack.delete(); exp_wr.delete();
      m_halt = 0; m_fault = 0; m_exec = 0; m_halt_ip = 0;
      while (!m_halt && m_exec < 3000) begin
         ins = rom[pc];
         op = int'(ins[27:24]); d = int'(ins[23:16]); s1 = int'(ins[15:8]); s0 = int'(ins[7:0]);
         a = m_regs[s1 % 16]; b = m_regs[s0 % 16];
         next = (pc + 1) % 256;
         m_exec++;
         case (op)
            1:  m_regs[d % 16] = (a + b) & MASK;
            2:  m_regs[d % 16] = (a - b) & MASK;
            3:  m_regs[d % 16] = ((s1 << 8) | s0) & MASK;
            4:  if (a <= b) next = d;
            5:  if (a == b) next = d;
            6:  next = d;
`ifdef MINI_ALU_SMUL_EN
            7:  m_regs[d % 16] = int'((longint'(a) * longint'(b)) & MASK);
`endif
            8:  if (m_stack.size() == 4) m_fault = 1; else begin m_stack.push_back(next); next = d; end
            9:  if (m_stack.size() == 0) m_fault = 1; else next = m_stack.pop_back();
            10: m_regs[d % 16] = (a + 1) & MASK;
            11: m_regs[d % 16] = a;
            12: colour = s1 % 8;
            13: exp_wr.push_back((((b % 64) * 128 + (a % 128)) * 8) + colour);
            14: m_halt = 1;
            default: ;
         endcase
         if (m_fault) m_halt = 1;
         if (m_halt) m_halt_ip = (pc + 1) % 256;
         else pc = next;
      end
   endtask

   task automatic gen_random(input int n);
      int ops[21] = '{0, 1, 1, 2, 2, 3, 3, 3, 4, 5, 6, 7, 7, 10, 11, 12, 13, 13, 15, 8, 9};
      int op, d;
      clear_rom();
      for (int i = 0; i < n; i++) begin
         op = ops[$urandom_range(0, 20)];
         d  = int'($urandom_range(0, 255));
         if (op == 4 || op == 5 || op == 6 || op == 8) d = int'($urandom_range(i + 1, n));
         rom[i] = mk(op, d, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      end
   endtask

   // ---------------- tests -------------------------------------------------
   task automatic test_reset();
      bit zero = 1;
      for (int i = 0; i < 256; i++) rom[i] = mk(0, 0, 0, 0);
      Reset = 0; #2 Reset = 1; #1;
      checks++;
      if (oIP !== 8'h00 || oVramWrValid !== 1'b0 || oHalted !== 1'b0 || oStackFault !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: ip=%h valid=%b halted=%b fault=%b, required 00 0 0 0",
                  oIP, oVramWrValid, oHalted, oStackFault);
      end
      for (int i = 0; i < 16; i++) if (dut.regs[i] !== 16'h0) zero = 0;
      checks++;
      if (!zero) begin errors++; $display("FAIL reset_regs: nonzero register, required all 0"); end
      @(negedge Clock); Reset = 0; #1;
      checks++;
      if (oIP !== 8'h00) begin errors++; $display("FAIL first_fetch: ip=%h, required 00", oIP); end
      @(posedge Clock); #1;
      checks++;
      if (oIP !== 8'h01) begin errors++; $display("FAIL second_fetch: ip=%h, required 01", oIP); end
   endtask

   task automatic test_arith();
      int edges; bit to;
      clear_rom();
      rom[0] = mk(3, 1, 0, 5); rom[1] = mk(3, 2, 0, 3);
      rom[2] = mk(1, 3, 1, 2); rom[3] = mk(2, 4, 2, 1);
      run_prog(edges, to);
      checks++;
      if (to || edges != 6) begin errors++; $display("FAIL arith_cycles: edges=%0d timeout=%0d, required 6", edges, to); end
      checks++;
      if (dut.regs[3] !== 16'd8) begin errors++; $display("FAIL arith_add: R3=%h, required 0008", dut.regs[3]); end
      checks++;
      if (dut.regs[4] !== 16'hFFFE) begin errors++; $display("FAIL arith_sub: R4=%h, required fffe", dut.regs[4]); end
      checks++;
      if (oIP !== 8'h05) begin errors++; $display("FAIL arith_halt_ip: ip=%h, required 05", oIP); end
   endtask

   task automatic test_call_nest();
      int edges; bit to;
      clear_rom();
      rom[8'h00] = mk(8, 8'h10, 0, 0); rom[8'h01] = mk(3, 5, 0, 8'hAA);
      rom[8'h10] = mk(8, 8'h20, 0, 0); rom[8'h11] = mk(10, 6, 6, 0); rom[8'h12] = mk(9, 0, 0, 0);
      rom[8'h20] = mk(8, 8'h30, 0, 0); rom[8'h21] = mk(10, 7, 7, 0); rom[8'h22] = mk(9, 0, 0, 0);
      rom[8'h30] = mk(3, 8, 0, 8'h33); rom[8'h31] = mk(9, 0, 0, 0);
      run_prog(edges, to);
      checks++;
      if (to || edges != 12) begin errors++; $display("FAIL call_cycles: edges=%0d timeout=%0d, required 12", edges, to); end
      checks++;
      if (dut.regs[5] !== 16'h00AA || dut.regs[6] !== 16'd1 || dut.regs[7] !== 16'd1 || dut.regs[8] !== 16'h0033) begin
         errors++;
         $display("FAIL call_resume: R5..R8=%h %h %h %h, required 00aa 0001 0001 0033",
                  dut.regs[5], dut.regs[6], dut.regs[7], dut.regs[8]);
      end
      checks++;
      if (oStackFault !== 1'b0 || oIP !== 8'h03) begin
         errors++; $display("FAIL call_end: fault=%b ip=%h, required 0 03", oStackFault, oIP);
      end
   endtask

   task automatic load_overflow();
      clear_rom();
      rom[8'h00] = mk(8, 8'h10, 0, 0); rom[8'h10] = mk(8, 8'h20, 0, 0);
      rom[8'h20] = mk(8, 8'h30, 0, 0); rom[8'h30] = mk(8, 8'h40, 0, 0);
      rom[8'h40] = mk(8, 8'h50, 0, 0); rom[8'h41] = mk(3, 1, 0, 1);
      rom[8'h50] = mk(3, 2, 0, 2);
   endtask

   task automatic test_stack_fault();
      int edges; bit to;
      load_overflow();
      run_prog(edges, to);
      checks++;
      if (to || edges != 6 || oStackFault !== 1'b1 || oHalted !== 1'b1) begin
         errors++;
         $display("FAIL overflow: edges=%0d fault=%b halted=%b, required 6 1 1", edges, oStackFault, oHalted);
      end
      repeat (3) @(negedge Clock);
      checks++;
      if (oIP !== 8'h41 || dut.regs[1] !== 16'h0 || dut.regs[2] !== 16'h0 || oVramWrValid !== 1'b0) begin
         errors++;
         $display("FAIL overflow_frozen: ip=%h R1=%h R2=%h valid=%b, required 41 0000 0000 0",
                  oIP, dut.regs[1], dut.regs[2], oVramWrValid);
      end
      clear_rom();
      rom[0] = mk(9, 0, 0, 0);
      run_prog(edges, to);
      checks++;
      if (to || edges != 2 || oStackFault !== 1'b1 || oIP !== 8'h01) begin
         errors++;
         $display("FAIL underflow: edges=%0d fault=%b ip=%h, required 2 1 01", edges, oStackFault, oIP);
      end
   endtask

   task automatic load_vram();
      clear_rom();
      rom[0] = mk(3, 1, 0, 7); rom[1] = mk(3, 2, 0, 2);
      rom[2] = mk(12, 0, 5, 0); rom[3] = mk(13, 0, 1, 2);
   endtask

   task automatic test_vram_stall();
      int edges; bit to;
      load_vram();
      rand_mode = 0; fixed_delay = 3;
      run_prog(edges, to);
      checks++;
      if (to || edges != 9) begin errors++; $display("FAIL vram_cycles: edges=%0d timeout=%0d, required 9", edges, to); end
      checks++;
      if (valid_cycles != 4) begin errors++; $display("FAIL vram_valid_len: cycles=%0d, required 4", valid_cycles); end
      checks++;
      if (obs_wr.size() != 1 || obs_wr[0] != {13'h107, 3'b101}) begin
         errors++;
         $display("FAIL vram_write: count=%0d first=%h, required 1 %h", obs_wr.size(),
                  obs_wr.size() > 0 ? obs_wr[0] : 0, {13'h107, 3'b101});
      end
      fixed_delay = 0;
   endtask

   task automatic test_reset_mid();
      int edges, n; bit to;
      load_overflow();
      run_prog(edges, to);
      @(negedge Clock); #2 Reset = 1; #1;
      checks++;
      if (oStackFault !== 1'b0 || oHalted !== 1'b0 || oIP !== 8'h00) begin
         errors++;
         $display("FAIL reset_after_fault: fault=%b halted=%b ip=%h, required 0 0 00", oStackFault, oHalted, oIP);
      end
      load_vram();
      fixed_delay = 1000;
      @(negedge Clock); @(negedge Clock); Reset = 0;
      n = 0;
      while (!oVramWrValid && n < 50) begin @(negedge Clock); n++; end
      checks++;
      if (!oVramWrValid) begin errors++; $display("FAIL reach_stall: valid=%b, required 1", oVramWrValid); end
      repeat (3) @(negedge Clock);
      #2 Reset = 1; #1;
      checks++;
      if (oVramWrValid !== 1'b0 || oIP !== 8'h00 || oHalted !== 1'b0 || dut.regs[1] !== 16'h0) begin
         errors++;
         $display("FAIL reset_in_stall: valid=%b ip=%h halted=%b R1=%h, required 0 00 0 0000",
                  oVramWrValid, oIP, oHalted, dut.regs[1]);
      end
      fixed_delay = 0;
      test_arith();
   endtask

   task automatic test_smul();
      int edges; bit to;
      logic [15:0] expv;
`ifdef MINI_ALU_SMUL_EN
      expv = 16'h5F90;
`else
      expv = 16'h1234;
`endif
      clear_rom();
      rom[0] = mk(3, 1, 8'h01, 8'h2C); rom[1] = mk(3, 3, 8'h12, 8'h34);
      rom[2] = mk(7, 3, 1, 1);
      run_prog(edges, to);
      checks++;
      if (to || edges != 5 || dut.regs[3] !== expv) begin
         errors++; $display("FAIL smul: edges=%0d R3=%h, required 5 %h", edges, dut.regs[3], expv);
      end
   endtask

   task automatic test_wrap();
      int edges; bit to;
      clear_rom();
      rom[0] = mk(10, 1, 1, 0); rom[1] = mk(3, 2, 0, 2);
      rom[2] = mk(5, 4, 1, 2);  rom[3] = mk(6, 8'hFF, 0, 0);
      rom[8'hFF] = mk(0, 0, 0, 0);
      run_prog(edges, to);
      checks++;
      if (to || edges != 10 || dut.regs[1] !== 16'd2 || oIP !== 8'h05) begin
         errors++;
         $display("FAIL ip_wrap: edges=%0d R1=%h ip=%h, required 10 0002 05", edges, dut.regs[1], oIP);
      end
   endtask

   task automatic test_random();
      int edges; bit to;
      rand_mode = 1;
      for (int t = 0; t < 6; t++) begin
         do begin gen_random(30 + t * 8); model_run(); end while (!m_halt);
         run_prog(edges, to);
         checks++;
         if (to || edges != m_exec + 1 + stall_cycles) begin
            errors++;
            $display("FAIL rand%0d_cycles: edges=%0d timeout=%0d, required %0d", t, edges, to, m_exec + 1 + stall_cycles);
         end
         checks++;
         if (oStackFault !== m_fault || oIP !== m_halt_ip[IPW-1:0]) begin
            errors++;
            $display("FAIL rand%0d_halt: fault=%b ip=%h, required %0d %h", t, oStackFault, oIP, m_fault, m_halt_ip);
         end
         for (int r = 0; r < 16; r++) begin
            checks++;
            if (dut.regs[r] !== m_regs[r][15:0]) begin
               errors++;
               $display("FAIL rand%0d_reg%0d: got %h, required %h", t, r, dut.regs[r], m_regs[r][15:0]);
            end
         end
         checks++;
         if (obs_wr.size() != exp_wr.size()) begin
            errors++;
            $display("FAIL rand%0d_wr_count: got %0d, required %0d", t, obs_wr.size(), exp_wr.size());
         end else begin
            foreach (exp_wr[k]) begin
               checks++;
               if (obs_wr[k] != exp_wr[k]) begin
                  errors++;
                  $display("FAIL rand%0d_wr%0d: got %h, required %h", t, k, obs_wr[k], exp_wr[k]);
               end
            end
         end
         repeat (3) @(negedge Clock);
         checks++;
         if (oIP !== m_halt_ip[IPW-1:0] || oVramWrValid !== 1'b0) begin
            errors++;
            $display("FAIL rand%0d_frozen: ip=%h valid=%b, required %h 0", t, oIP, oVramWrValid, m_halt_ip);
         end
      end
      rand_mode = 0;
   endtask

   initial begin
      Reset = 0;
      test_reset();
      test_arith();
      test_call_nest();
      test_stack_fault();
      test_vram_stall();
      test_smul();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
